// File: rtl/fpu_pkg.sv
// Shared types and constants for the APB front-end of the FPU.
// Holds opcode/state enums, register offsets and STATUS/CTRL bit indices.
package fpu_pkg;

    typedef enum logic [2:0] {
        FPU_ADD = 3'b000,
        FPU_SUB = 3'b001,
        FPU_MUL = 3'b010,
        OP_NONE = 3'b111
    } fpu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } fpu_state_e;

    localparam logic [7:0] REG_OP1    = 8'h00;
    localparam logic [7:0] REG_OP2    = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;
    localparam logic [7:0] REG_RESULT = 8'h10;

    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_START  = 8;

    localparam int ST_BUSY_BIT = 0;
    localparam int ST_DONE_BIT = 1;
    localparam int ST_ERR_BIT  = 2;
    localparam int ST_ZERO_BIT = 3;
    localparam int ST_INF_BIT  = 4;
    localparam int ST_NAN_BIT  = 5;

    localparam logic [2:0] OP_MAX = 3'd2;

endpackage

// File: rtl/fpu_apb_regfile.sv
// APB register file: decode, operand/ctrl/status/result storage, W1C, pslverr.
// Ports: APB slave signals in, prdata/pslverr out; busy and hw_* completion
// inputs from the FSM; op1/op2/opcode/start_go/irq out.
module fpu_apb_regfile
    import fpu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pslverr,
    input  logic              busy,
    input  logic              hw_done,
    input  logic              hw_err,
    input  logic [31:0]       hw_result,
    input  logic              hw_zero,
    input  logic              hw_inf,
    input  logic              hw_nan,
    output logic [31:0]       op1,
    output logic [31:0]       op2,
    output logic [2:0]        opcode,
    output logic              start_go,
    output logic              irq
);

    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] result_q;
    logic [2:0]  opcode_q;
    logic        irq_en_q;
    logic        done_q;
    logic        err_q;
    logic        zero_q;
    logic        inf_q;
    logic        nan_q;
    logic        irq_q;

    logic acc;
    logic wr;
    logic sel_op1;
    logic sel_op2;
    logic sel_ctrl;
    logic sel_stat;
    logic sel_res;
    logic mapped;
    logic bad_start;
    logic wr_op1;
    logic wr_op2;
    logic wr_ctrl;
    logic wr_stat;
    logic done_d;
    logic err_d;

    assign acc      = psel & penable;
    assign wr       = acc & pwrite;
    assign sel_op1  = (paddr == ADDR_W'(REG_OP1));
    assign sel_op2  = (paddr == ADDR_W'(REG_OP2));
    assign sel_ctrl = (paddr == ADDR_W'(REG_CTRL));
    assign sel_stat = (paddr == ADDR_W'(REG_STATUS));
    assign sel_res  = (paddr == ADDR_W'(REG_RESULT));
    assign mapped   = sel_op1 | sel_op2 | sel_ctrl
                    | sel_stat | sel_res;

    // Illegal start: rejected, but still flagged through err.
    assign bad_start = wr & sel_ctrl & ~busy
                     & pwdata[CTRL_START]
                     & (pwdata[2:0] > OP_MAX);

    assign wr_op1  = wr & sel_op1 & ~busy;
    assign wr_op2  = wr & sel_op2 & ~busy;
    assign wr_ctrl = wr & sel_ctrl & ~busy & ~bad_start;
    assign wr_stat = wr & sel_stat;

    assign start_go = wr_ctrl & pwdata[CTRL_START];

    always_comb begin
        pslverr = 1'b0;
        if (wr) begin
            pslverr = ~mapped | sel_res | bad_start
                    | (busy & (sel_op1 | sel_op2 | sel_ctrl));
        end
    end

    // Hardware sets take priority over software W1C.
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (wr_stat && pwdata[ST_DONE_BIT]) done_d = 1'b0;
        if (wr_stat && pwdata[ST_ERR_BIT])  err_d  = 1'b0;
        if (start_go) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (hw_done)             done_d = 1'b1;
        if (hw_err || bad_start) err_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            opcode_q <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_op1) op1_q <= pwdata;
            if (wr_op2) op2_q <= pwdata;
            if (wr_ctrl) begin
                opcode_q <= pwdata[2:0];
                irq_en_q <= pwdata[CTRL_IRQ_EN];
            end
            if (hw_done) begin
                result_q <= hw_result;
                zero_q   <= hw_zero;
                inf_q    <= hw_inf;
                nan_q    <= hw_nan;
            end
            done_q <= done_d;
            err_q  <= err_d;
            irq_q  <= irq_en_q & (done_q | err_q);
        end
    end

    always_comb begin
        prdata = '0;
        if (acc && !pwrite) begin
            unique case (1'b1)
                sel_op1:  prdata = op1_q;
                sel_op2:  prdata = op2_q;
                sel_ctrl: prdata = {28'b0, irq_en_q, opcode_q};
                sel_stat: prdata = {26'b0, nan_q, inf_q, zero_q,
                                    err_q, done_q, busy};
                sel_res:  prdata = result_q;
                default:  prdata = '0;
            endcase
        end
    end

    assign op1    = op1_q;
    assign op2    = op2_q;
    assign opcode = opcode_q;
    assign irq    = irq_q;

endmodule

// File: rtl/fpu_apb_ctrl.sv
// APB3 front-end for the FPU: one-at-a-time issue, result/flag capture.
// Ports: APB3 slave (psel..pslverr), irq, and the FPU op/result interface.
module fpu_apb_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq,
    output logic [31:0]       fpu_op1,
    output logic [31:0]       fpu_op2,
    output logic [2:0]        fpu_op_select,
    input  logic [31:0]       fpu_result,
    input  logic              fpu_valid,
    input  logic              fpu_zero,
    input  logic              fpu_inf,
    input  logic              fpu_nan
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    fpu_state_e       state_q;
    fpu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fin_ok;
    logic             fin_to;
    logic             start_go;
    logic             busy;
    logic [2:0]       opcode;

    assign busy   = (state_q == ST_BUSY);
    assign pready = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_ok  = 1'b0;
        fin_to  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (fpu_valid) begin
                    fin_ok  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    fin_to  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Opcode register cannot change in BUSY since CTRL writes are blocked.
    assign fpu_op_select = busy ? opcode : OP_NONE;

    fpu_apb_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .busy      (busy),
        .hw_done   (fin_ok),
        .hw_err    (fin_to),
        .hw_result (fpu_result),
        .hw_zero   (fpu_zero),
        .hw_inf    (fpu_inf),
        .hw_nan    (fpu_nan),
        .op1       (fpu_op1),
        .op2       (fpu_op2),
        .opcode    (opcode),
        .start_go  (start_go),
        .irq       (irq)
    );

endmodule

// File: doc/fpu_apb_ctrl.md
# fpu_apb_ctrl

APB3 slave front-end that sits directly upstream of the floating-point unit inside the `apb_fpu` peripheral. It holds the operand and opcode registers and issues one operation at a time to the FPU datapath. It waits for the FPU's valid strobe, latches the result and the zero/INF/NaN flags, and raises a sticky done or error status with an optional interrupt.

## Interface
- `TIMEOUT`, 64 — max cycles in BUSY before abort; ≥2.
- `ADDR_W`, 5 — PADDR width.
- `clk` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `psel`, `penable`, `pwrite` in 1 — APB3 control.
- `paddr` in ADDR_W — byte address, word aligned.
- `pwdata` in 32 — write data.
- `prdata` out 32 — read data.
- `pready` out 1 — tied 1; no wait states.
- `pslverr` out 1 — error response.
- `irq` out 1 — level interrupt.
- `fpu_op1`, `fpu_op2` out 32 — operands to FPU.
- `fpu_op_select` out 3 — 000 add, 001 sub, 010 mul; `OP_NONE`=3'b111 when not BUSY.
- `fpu_result` in 32 — FPU result.
- `fpu_valid` in 1 — FPU result valid.
- `fpu_zero`, `fpu_inf`, `fpu_nan` in 1 — FPU flags.

## Operation
- Access phase: `psel & penable`. Writes commit at that edge; `prdata` is combinational during the access phase.
- Register map:
  - 0x00 OP1 (RW).
  - 0x04 OP2 (RW).
  - 0x08 CTRL: [2:0] opcode RW, [3] irq_en RW, [8] start (write-only, reads 0).
  - 0x0C STATUS: [0] busy RO, [1] done W1C, [2] err W1C, [3] zero, [4] inf, [5] nan RO (latched).
  - 0x10 RESULT (RO).
  - Other addresses read 0.
- FSM has two states, IDLE and BUSY.
  - IDLE→BUSY: write to CTRL with start=1 and opcode ≤ 2. Same edge: load opcode, clear done/err, clear cycle counter.
  - In BUSY, `fpu_op_select` = opcode. `fpu_op1`/`fpu_op2` always mirror OP1/OP2.
  - BUSY→IDLE on `fpu_valid`: latch `fpu_result` into RESULT and the flags into STATUS[5:3]; set done.
  - BUSY→IDLE on timeout: counter reaches TIMEOUT-1 without `fpu_valid`. Set err; RESULT and flags unchanged.
- `pslverr`=1 and the write is ignored (no state change) for:
  - start with opcode > 2 (this also sets err);
  - any write to OP1, OP2 or CTRL while BUSY;
  - a write to an unmapped address or to RESULT.
- Reads never error.
- `irq` = irq_en & (done | err), registered.
- W1C write to STATUS on the same edge as a hardware set of done/err: the set wins.

## Timing
- Reset values: all registers 0, state IDLE, `fpu_op_select`=OP_NONE, `prdata`=0, `pslverr`=0, `irq`=0, `pready`=1.
- Start write at edge N: BUSY from N. `fpu_op_select` is valid in cycle N+1 and `fpu_valid` is sampled from edge N+1.
- Minimum latency is 1 cycle (combinational add/sub): done=1 and RESULT updated at edge N+1. Multiply latency is whatever the FPU takes, bounded by TIMEOUT.
- busy reads 1 from cycle N+1 until the completing edge.
- `irq` rises one cycle after done/err sets and falls one cycle after clear.
- Operands are held stable for the whole of BUSY (writes blocked). `fpu_valid` is ignored outside BUSY.
- Reset asserted mid-BUSY: next edge returns to IDLE and `fpu_op_select`=OP_NONE. Any late `fpu_valid` is ignored.

## Structure
- Package `fpu_pkg`:
  - opcode enum (`FPU_ADD`, `FPU_SUB`, `FPU_MUL`, `OP_NONE`);
  - register offset localparams;
  - STATUS/CTRL bit-index constants;
  - FSM state enum.
- One sub-module is natural: `fpu_apb_regfile` (address decode, register storage, W1C, pslverr generation). The FSM and timeout counter stay in the top.
- Counter width is `$clog2(TIMEOUT)`.

## Test plan
- Add: OP1=0x3F800000, OP2=0x40000000, CTRL=0x000|start. With a combinational model, done=1 one cycle later, RESULT=0x40400000, zero/inf/nan=0.
- Multiply: OP1=0x40000000, OP2=0x40400000, opcode 010. The model returns valid after 5 cycles: busy=1 for 5 cycles, then RESULT=0x40C00000 and done=1. With irq_en=1, irq=1 the following cycle.
- Subtract: 1.0−1.0 → RESULT=0x00000000, zero=1. Then W1C 0x2 to STATUS → done=0 and irq falls.
- Timeout: TIMEOUT=16, model never asserts valid. err=1 exactly 16 cycles after start, RESULT unchanged, `fpu_op_select` returns to 111.
- Errors:
  - start with opcode 011 → pslverr=1, err=1, FSM stays IDLE;
  - write to OP1 while BUSY → pslverr=1 and OP1 unchanged;
  - write to 0x14 → pslverr=1.
- Reset mid-multiply at cycle 2 of BUSY, then `fpu_valid` pulses → state IDLE, RESULT=0, done=0.
